keypad_emulator: RTL and testbench
==================================

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 4000, clk cycles of contact bounce per edge; 0 disables bounce.
REQ-002 Parameter BOUNCE_PERIOD, default 100, clk cycles between bounce contact updates; minimum 1.
REQ-003 Parameter GAP_CYCLES, default 1000, clk cycles of guaranteed open contact after release before the next press.
REQ-004 clk  input  1  single system clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-low reset (logic 0 resets on a clk edge).
REQ-006 key_valid  input  1  press request valid.
REQ-007 key_code  input  4  key to press, {row[1:0], column[1:0]}.
REQ-008 hold_cycles  input  24  stable-closed duration in clk cycles; 0 treated as 1.
REQ-009 key_ready  output  1  request accepted on a clk edge where key_valid and key_ready are both 1.
REQ-010 keypad_column  input  4  active-low column strobes from the scanner.
REQ-011 keypad_row  output  4  active-low row lines returned to the scanner.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a press/release sequence completes.

Function
REQ-014 FSM states: IDLE, BOUNCE_PRESS, HOLD, BOUNCE_RELEASE, GAP.
REQ-015 key_ready = 1 only in IDLE; accepted key_code and hold_cycles are latched and held stable for the whole sequence.
REQ-016 Transitions: IDLE->BOUNCE_PRESS on accept; BOUNCE_PRESS->HOLD after BOUNCE_CYCLES cycles; HOLD->BOUNCE_RELEASE after the latched hold count; BOUNCE_RELEASE->GAP after BOUNCE_CYCLES cycles; GAP->IDLE after GAP_CYCLES cycles.
REQ-017 BOUNCE_CYCLES = 0: BOUNCE_PRESS and BOUNCE_RELEASE are skipped (IDLE->HOLD, HOLD->GAP directly).
REQ-018 GAP_CYCLES = 0: GAP lasts exactly one cycle.
REQ-019 Registered contact state: open in IDLE and GAP, closed in HOLD, pseudo-random in bounce states.
REQ-020 In bounce states the contact is loaded from the LFSR output bit once every BOUNCE_PERIOD cycles; the LFSR advances once per update.
REQ-021 First cycle of HOLD: contact closed. First cycle of GAP: contact open, regardless of the LFSR.
REQ-022 keypad_row[r] = 0 iff contact is closed, r = latched row, and keypad_column[c] = 0 for latched column c; all other row bits are 1.
REQ-023 keypad_row is combinational from keypad_column and the registered contact state (zero-cycle path, like a passive switch).
REQ-024 Multiple columns low at once: only the latched column affects the output; the other columns are ignored.
REQ-025 done pulses in the single cycle in which the FSM transitions GAP->IDLE; key_ready is high in the following cycle.
REQ-026 key_valid while busy: ignored, no state change, nothing queued.
REQ-027 Duration counters are 24-bit, count down and saturate at 0; there is no wrap-around.

Reset
REQ-028 On reset = 0 at a clk edge: state IDLE, contact open, counters 0, LFSR = 8'hA5, done 0.
REQ-029 After reset: keypad_row = 4'b1111, key_ready = 1, busy = 0.
REQ-030 Reset mid-sequence aborts the sequence with no done pulse; keypad_row is 4'b1111 from the next edge.

Structure
REQ-031 Shared package keypad_pkg holds the FSM state enum, key-code typedef (row/column 2-bit fields) and the LFSR seed constant.
REQ-032 Sub-module lfsr8: Fibonacci x^8+x^6+x^5+x^4+1, with enable and synchronous active-low reset to the seed; reused by future bench stimulus.

Verification (BOUNCE_CYCLES=16, BOUNCE_PERIOD=2, GAP_CYCLES=8)
REQ-033 Key 4'b0110, hold 20, column held 4'b1011: row = 4'b1111 through bounce end; row = 4'b1101 for exactly 20 cycles of HOLD; done occurs 16+20+16+8 cycles after accept.
REQ-034 Same press with column cycling 1110/1101/1011/0111: row[1] low only while column = 4'b1011 and the state is HOLD.
REQ-035 key_valid reasserted with key 4'hF during HOLD: key_ready = 0, latched key unchanged, only one done pulse.
REQ-036 reset = 0 asserted mid-HOLD: row = 4'b1111 next cycle, state IDLE, no done, key_ready = 1.
REQ-037 BOUNCE_CYCLES=0, hold 0: row low for exactly 1 cycle, then GAP for 8 cycles, then done.
REQ-038 Back-to-back requests with key_valid held high: second accept occurs exactly one cycle after done; row stays 4'b1111 for all GAP cycles.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types for the keypad emulator: FSM states, key-code layout, LFSR seed.
// Also the saturating "duration minus one" helper used to load the duration counters.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_PRESS,
    HOLD,
    BOUNCE_RELEASE,
    GAP
  } state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_code_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam int         CNT_W     = 24;

  // A state lasting n cycles loads n-1 and leaves when the counter reads 0.
  function automatic logic [CNT_W-1:0] cnt_load(input logic [CNT_W-1:0] n);
    return (n == '0) ? '0 : n - CNT_W'(1);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), MSB is the output bit, one step per enabled clk.
// Synchronous active-low reset returns it to LFSR_SEED; no backpressure.
module lfsr8
  import keypad_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic out
);

  logic [7:0] q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= LFSR_SEED;
    end else if (enable) begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

  assign out = q[7];

endmodule

// File: rtl/keypad_emulator.sv
// Emulates one key of a 4x4 matrix keypad: bounce, hold, bounce, guaranteed-open gap.
// Requests accepted only in IDLE (key_ready); keypad_row is a zero-cycle path from keypad_column.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_CYCLES = 4000,
  parameter int BOUNCE_PERIOD = 100,
  parameter int GAP_CYCLES    = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic [CNT_W-1:0] hold_cycles,
  output logic             key_ready,
  input  logic [3:0]       keypad_column,
  output logic [3:0]       keypad_row,
  output logic             busy,
  output logic             done
);

  localparam bit              NO_BOUNCE   = (BOUNCE_CYCLES == 0);
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = cnt_load(CNT_W'(BOUNCE_CYCLES));
  localparam logic [CNT_W-1:0] PERIOD_LOAD = cnt_load(CNT_W'(BOUNCE_PERIOD));
  localparam logic [CNT_W-1:0] GAP_LOAD    = cnt_load(CNT_W'(GAP_CYCLES));

  state_t           state, state_nxt;
  key_code_t        key_q;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] pcnt;
  logic             contact, contact_nxt;
  logic             lfsr_en, lfsr_bit;
  logic             cnt_zero, in_bounce, tick;

  assign cnt_zero  = (cnt == '0);
  assign in_bounce = (state == BOUNCE_PRESS) || (state == BOUNCE_RELEASE);
  assign tick      = in_bounce && (pcnt == '0);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      contact <= 1'b0;
      key_q   <= '0;
      hold_q  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      contact <= contact_nxt;
      if (key_valid && key_ready) begin
        key_q  <= key_code;
        hold_q <= hold_cycles;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_zero ? '0 : cnt - CNT_W'(1);
    key_ready = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          if (NO_BOUNCE) begin
            state_nxt = HOLD;
            cnt_nxt   = cnt_load(hold_cycles);
          end else begin
            state_nxt = BOUNCE_PRESS;
            cnt_nxt   = BOUNCE_LOAD;
          end
        end
      end
      BOUNCE_PRESS: if (cnt_zero) begin
        state_nxt = HOLD;
        cnt_nxt   = cnt_load(hold_q);
      end
      HOLD: if (cnt_zero) begin
        state_nxt = NO_BOUNCE ? GAP : BOUNCE_RELEASE;
        cnt_nxt   = NO_BOUNCE ? GAP_LOAD : BOUNCE_LOAD;
      end
      BOUNCE_RELEASE: if (cnt_zero) begin
        state_nxt = GAP;
        cnt_nxt   = GAP_LOAD;
      end
      GAP: if (cnt_zero) begin
        state_nxt = IDLE;
        done      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Entering HOLD/GAP forces the contact; bounce keeps the entry value until the first update.
  always_comb begin
    contact_nxt = contact;
    lfsr_en     = 1'b0;
    case (state_nxt)
      HOLD:      contact_nxt = 1'b1;
      IDLE, GAP: contact_nxt = 1'b0;
      default: begin
        if (tick && (state_nxt == state)) begin
          contact_nxt = lfsr_bit;
          lfsr_en     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt <= '0;
    end else if ((state_nxt != state) || (pcnt == '0)) begin
      pcnt <= PERIOD_LOAD;
    end else begin
      pcnt <= pcnt - CNT_W'(1);
    end
  end

  lfsr8 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (lfsr_en),
    .out    (lfsr_bit)
  );

  always_comb begin
    keypad_row = 4'hF;
    if (contact && !keypad_column[key_q.col]) begin
      keypad_row[key_q.row] = 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: a bounced instance (16/2/8) and a bounce-free one (0/2/8), both
// checked every cycle against a per-cycle contact timeline built at accept time.
module tb_keypad_emulator;

  localparam int BC   = 16;
  localparam int BPER = 2;
  localparam int GC   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid, key_valid0;
  logic [3:0]  key_code;
  logic [23:0] hold_cycles;
  logic [3:0]  keypad_column;
  logic        rdy_o  [2];
  logic        busy_o [2];
  logic        done_o [2];
  logic [3:0]  row_o  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_emulator #(.BOUNCE_CYCLES(BC), .BOUNCE_PERIOD(BPER), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .hold_cycles(hold_cycles), .key_ready(rdy_o[0]), .keypad_column(keypad_column),
    .keypad_row(row_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  keypad_emulator #(.BOUNCE_CYCLES(0), .BOUNCE_PERIOD(BPER), .GAP_CYCLES(GC)) dut0 (
    .clk(clk), .reset(reset), .key_valid(key_valid0), .key_code(key_code),
    .hold_cycles(hold_cycles), .key_ready(rdy_o[1]), .keypad_column(keypad_column),
    .keypad_row(row_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  // Reference model: the whole press is expanded into a list of per-cycle contact values.
  bit         seq  [2][512];
  int         len  [2];
  int         pos  [2];
  logic [7:0] ml   [2];
  logic [3:0] mkey [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build(input int i);
    int n = 0;
    int nb = (i == 0) ? BC : 0;
    int h = (hold_cycles == 24'd0) ? 1 : int'(hold_cycles);
    int g = (GC == 0) ? 1 : GC;
    bit c;
    mkey[i] = key_code;
    for (int ph = 0; ph < 2; ph++) begin
      c = (ph == 1);
      for (int e = 0; e < nb; e++) begin
        if (e > 0 && (e % BPER) == 0) begin
          c = ml[i][7];
          ml[i] = {ml[i][6:0], ^(ml[i] & 8'hB8)};
        end
        seq[i][n] = c;
        n++;
      end
      if (ph == 0) begin
        for (int k = 0; k < h; k++) begin seq[i][n] = 1'b1; n++; end
      end
    end
    for (int k = 0; k < g; k++) begin seq[i][n] = 1'b0; n++; end
    len[i] = n;
    pos[i] = 0;
  endtask

  task automatic model_step(input int i, input logic rst, input logic vld);
    if (!rst) begin
      len[i] = 0; pos[i] = 0; ml[i] = 8'hA5;
    end else if (len[i] != 0) begin
      pos[i]++;
      if (pos[i] == len[i]) begin len[i] = 0; pos[i] = 0; end
    end else if (vld) begin
      build(i);
    end
  endtask

  task automatic compare(input int i);
    bit b, cont;
    logic [3:0] er;
    b    = (len[i] != 0);
    cont = b && seq[i][pos[i]];
    er   = 4'hF;
    if (cont && !keypad_column[mkey[i][1:0]]) er[mkey[i][3:2]] = 1'b0;
    check($sformatf("row[%0d]", i), 32'(row_o[i]), 32'(er));
    check($sformatf("key_ready[%0d]", i), 32'(rdy_o[i]), 32'(!b));
    check($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(b));
    check($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(b && pos[i] == len[i] - 1));
  endtask

  always @(posedge clk) begin
    model_step(0, reset, key_valid);
    model_step(1, reset, key_valid0);
    #3;
    for (int i = 0; i < 2; i++) compare(i);
  end

  task automatic tick();
    @(posedge clk);
    #4;
  endtask

  task automatic press(input int i, input logic [3:0] code, input logic [23:0] hold);
    key_code = code;
    hold_cycles = hold;
    if (i == 0) key_valid = 1'b1; else key_valid0 = 1'b1;
    tick();
    key_valid = 1'b0;
    key_valid0 = 1'b0;
  endtask

  // Runs until idle; cycle numbers count from 1 = first cycle after the accepting edge.
  task automatic run_to_done(input int i, input int c0, input bit cyc_cols, input int wlo,
                             input int whi, output int done_cyc, output int low_cyc,
                             output int win_low, output int ndone);
    logic [3:0] pats [4];
    int c = c0;
    pats[0] = 4'b1110; pats[1] = 4'b1101; pats[2] = 4'b1011; pats[3] = 4'b0111;
    done_cyc = -1; low_cyc = 0; win_low = 0; ndone = 0;
    while (busy_o[i] && c < 400) begin
      if (cyc_cols) begin keypad_column = pats[c % 4]; #1; end
      if (row_o[i] != 4'hF) begin
        low_cyc++;
        if (c >= wlo && c <= whi) win_low++;
      end
      if (done_o[i]) begin ndone++; if (done_cyc < 0) done_cyc = c; end
      tick();
      c++;
    end
    check($sformatf("idle_after_seq[%0d]", i), 32'(busy_o[i]), 32'd0);
  endtask

  typedef struct { logic [3:0] col; logic [3:0] row; } vec_t;

  initial begin
    vec_t tbl [8];
    int dc, lc, wl, nd, exp_w, fd, idle_n;
    bit second;

    tbl[0] = '{4'b1110, 4'b1111}; tbl[1] = '{4'b1101, 4'b1111};
    tbl[2] = '{4'b1011, 4'b1101}; tbl[3] = '{4'b0111, 4'b1111};
    tbl[4] = '{4'b0000, 4'b1101}; tbl[5] = '{4'b1111, 4'b1111};
    tbl[6] = '{4'b1010, 4'b1101}; tbl[7] = '{4'b0101, 4'b1111};

    reset = 1'b0; key_valid = 1'b0; key_valid0 = 1'b0;
    key_code = 4'h0; hold_cycles = 24'd0; keypad_column = 4'b1011;
    tick(); tick();
    check("reset_row", 32'(row_o[0]), 32'hF);
    check("reset_ready", 32'(rdy_o[0]), 32'd1);
    check("reset_busy", 32'(busy_o[0]), 32'd0);
    check("reset_done", 32'(done_o[0]), 32'd0);
    reset = 1'b1;
    tick();

    // Key 0110, hold 20, column 1011 held: HOLD is cycles 17..36, done in cycle 60.
    press(0, 4'b0110, 24'd20);
    run_to_done(0, 1, 1'b0, BC + 1, BC + 20, dc, lc, wl, nd);
    check("basic_done_cycle", dc, BC + 20 + BC + GC);
    check("basic_hold_low_cycles", wl, 20);
    check("basic_done_count", nd, 1);

    // Same press with rotating column strobes.
    press(0, 4'b0110, 24'd20);
    run_to_done(0, 1, 1'b1, BC + 1, BC + 20, dc, lc, wl, nd);
    exp_w = 0;
    for (int c = BC + 1; c <= BC + 20; c++) if (c % 4 == 2) exp_w++;
    check("scan_hold_low_cycles", wl, exp_w);
    check("scan_done_cycle", dc, BC + 20 + BC + GC);
    keypad_column = 4'b1011;

    // Column table applied inside HOLD (hold 40, cycles 17..56).
    press(0, 4'b0110, 24'd40);
    repeat (20) tick();
    foreach (tbl[k]) begin
      keypad_column = tbl[k].col;
      #1;
      check($sformatf("table_row_%0d", k), 32'(row_o[0]), 32'(tbl[k].row));
      tick();
    end
    keypad_column = 4'b1011;
    run_to_done(0, 29, 1'b0, 0, 0, dc, lc, wl, nd);
    check("table_done_cycle", dc, BC + 40 + BC + GC);

    // New request during HOLD is ignored.
    press(0, 4'b0110, 24'd20);
    repeat (20) tick();
    key_valid = 1'b1; key_code = 4'hF; hold_cycles = 24'd5;
    tick();
    check("busy_req_ready", 32'(rdy_o[0]), 32'd0);
    check("busy_req_row_latched", 32'(row_o[0]), 32'b1101);
    repeat (4) tick();
    key_valid = 1'b0;
    run_to_done(0, 26, 1'b0, 0, 0, dc, lc, wl, nd);
    check("busy_req_done_count", nd, 1);
    check("busy_req_done_cycle", dc, BC + 20 + BC + GC);

    // Reset in the middle of HOLD.
    press(0, 4'b0110, 24'd40);
    repeat (20) tick();
    check("pre_reset_row", 32'(row_o[0]), 32'b1101);
    reset = 1'b0;
    tick();
    check("mid_reset_row", 32'(row_o[0]), 32'hF);
    check("mid_reset_ready", 32'(rdy_o[0]), 32'd1);
    check("mid_reset_busy", 32'(busy_o[0]), 32'd0);
    check("mid_reset_done", 32'(done_o[0]), 32'd0);
    reset = 1'b1;
    tick();

    // Bounce-free instance, hold 0: one closed cycle, eight GAP cycles.
    press(1, 4'b0110, 24'd0);
    run_to_done(1, 1, 1'b0, 1, 1, dc, lc, wl, nd);
    check("nobounce_low_cycles", lc, 1);
    check("nobounce_done_cycle", dc, 1 + GC);

    // Back-to-back with key_valid held high.
    key_code = 4'b0110; hold_cycles = 24'd3; key_valid = 1'b1;
    tick();
    fd = -1; idle_n = 0; second = 1'b0;
    for (int c = 1; c <= 200 && !second; c++) begin
      if (fd >= 0 && c > fd) begin
        if (busy_o[0]) second = 1'b1; else idle_n++;
      end
      if (done_o[0] && fd < 0) fd = c;
      if (!second) tick();
    end
    key_valid = 1'b0;
    check("b2b_first_done_cycle", fd, BC + 3 + BC + GC);
    check("b2b_second_accept", 32'(second), 32'd1);
    check("b2b_idle_cycles", idle_n, 1);
    run_to_done(0, 1, 1'b0, 0, 0, dc, lc, wl, nd);
    check("b2b_second_done_count", nd, 1);

    // Random traffic on both instances, including occasional resets.
    for (int c = 0; c < 3000; c++) begin
      key_valid     = ($urandom_range(0, 3) == 0);
      key_valid0    = ($urandom_range(0, 3) == 0);
      key_code      = 4'($urandom);
      hold_cycles   = 24'($urandom_range(0, 12));
      keypad_column = 4'($urandom);
      reset         = ($urandom_range(0, 299) != 0);
      tick();
    end
    key_valid = 1'b0; key_valid0 = 1'b0; reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
